// File: rtl/lsu_pkg.sv
// Shared types and size encodings for the load/store sequencer.
package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT_RD = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERR     = 3'd4,
        ST_DRAIN   = 3'd5
    } lsu_state_t;

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;

endpackage

// File: rtl/lsu_ctrl_align.sv
// Byte-lane steering: store replication/enables, load extraction/extension,
// and the alignment check for the incoming access.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_unsigned,
    input  logic [31:0] ld_rdata,
    output logic [31:0] lane_wdata,
    output logic [3:0]  lane_be,
    output logic        misaligned,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = ld_rdata[{ld_off, 3'b000} +: 8];
    assign half_s = ld_rdata[{ld_off[1], 4'b0000} +: 16];

    // Store lane replication, byte enables and alignment check
    always_comb begin
        lane_wdata = st_wdata;
        lane_be    = 4'b0000;
        misaligned = 1'b0;
        case (st_size)
            LS_BYTE: begin
                lane_wdata = {4{st_wdata[7:0]}};
                lane_be    = 4'b0001 << st_off;
            end
            LS_HALF: begin
                lane_wdata = {2{st_wdata[15:0]}};
                lane_be    = 4'b0011 << st_off;
                misaligned = st_off[0];
            end
            LS_WORD: begin
                lane_be    = 4'b1111;
                misaligned = (st_off != 2'b00);
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

    // Load extraction with sign or zero extension
    always_comb begin
        ld_data = ld_rdata;
        case (ld_size)
            LS_BYTE: ld_data = {{24{~ld_unsigned & byte_s[7]}}, byte_s};
            LS_HALF: ld_data = {{16{~ld_unsigned & half_s[15]}}, half_s};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: accepts one memory access at a time, runs the data-bus
// handshake, stalls the pipeline and reports misalignment and bus timeouts.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        req_valid_in,
    input  logic        is_load_in,
    input  logic        mem_wr_req_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic        flush_in,
    output logic        dmem_req_out,
    output logic        dmem_we_out,
    output logic [31:0] dmem_addr_out,
    output logic [31:0] dmem_wdata_out,
    output logic [3:0]  dmem_be_out,
    input  logic        dmem_ready_in,
    input  logic        dmem_rvalid_in,
    input  logic [31:0] dmem_rdata_in,
    output logic        stall_out,
    output logic        load_valid_out,
    output logic [31:0] load_data_out,
    output logic        misaligned_out,
    output logic        bus_err_out
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state_r, state_s;
    logic [CW-1:0] cnt_r;
    logic        accept_s, mis_s, timeout_s, stall_s;
    logic [31:0] lane_wdata_s, ld_data_s;
    logic [3:0]  lane_be_s;
    logic [31:0] addr_r, wdata_r, load_data_r;
    logic [3:0]  be_r;
    logic [1:0]  size_r, off_r;
    logic        we_r, uns_r, err_bus_r;

    assign accept_s  = req_valid_in & (is_load_in | mem_wr_req_in) & ~flush_in;
    assign timeout_s = (cnt_r == CNT_LAST);

    lsu_align u_align (
        .st_size     (load_size_in),
        .st_off      (addr_in[1:0]),
        .st_wdata    (wdata_in),
        .ld_size     (size_r),
        .ld_off      (off_r),
        .ld_unsigned (uns_r),
        .ld_rdata    (dmem_rdata_in),
        .lane_wdata  (lane_wdata_s),
        .lane_be     (lane_be_s),
        .misaligned  (mis_s),
        .ld_data     (ld_data_s)
    );

    // Next-state and pipeline stall decode
    always_comb begin
        state_s = state_r;
        stall_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    stall_s = 1'b1;
                    state_s = mis_s ? ST_ERR : ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                stall_s = 1'b1;
                if (dmem_ready_in) begin
                    // A flushed load still owes a read response, so it must drain.
                    if (flush_in) begin
                        state_s = we_r ? ST_IDLE : ST_DRAIN;
                    end else begin
                        state_s = we_r ? ST_DONE : ST_WAIT_RD;
                    end
                end else if (flush_in) begin
                    state_s = ST_IDLE;
                end else if (timeout_s) begin
                    state_s = ST_ERR;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT_RD: begin
                stall_s = 1'b1;
                if (dmem_rvalid_in) begin
                    state_s = flush_in ? ST_IDLE : ST_DONE;
                end else if (flush_in) begin
                    state_s = ST_DRAIN;
                end else if (timeout_s) begin
                    state_s = ST_ERR;
                end else begin
                    state_s = ST_WAIT_RD;
                end
            end
            ST_DRAIN: begin
                stall_s = req_valid_in;
                if (dmem_rvalid_in || timeout_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            ST_ERR:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register and per-state cycle counter
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_s;
            if (state_s != state_r) begin
                cnt_r <= {CW{1'b0}};
            end else if (state_r == ST_REQ || state_r == ST_WAIT_RD || state_r == ST_DRAIN) begin
                cnt_r <= cnt_r + CW'(1'b1);
            end
        end
    end

    // Access capture at acceptance, read data capture and error kind
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            addr_r      <= 32'h0000_0000;
            wdata_r     <= 32'h0000_0000;
            be_r        <= 4'b0000;
            we_r        <= 1'b0;
            size_r      <= 2'b00;
            off_r       <= 2'b00;
            uns_r       <= 1'b0;
            load_data_r <= 32'h0000_0000;
            err_bus_r   <= 1'b0;
        end else begin
            if (state_r == ST_IDLE && accept_s) begin
                addr_r  <= {addr_in[31:2], 2'b00};
                wdata_r <= lane_wdata_s;
                be_r    <= lane_be_s;
                we_r    <= mem_wr_req_in;
                size_r  <= load_size_in;
                off_r   <= addr_in[1:0];
                uns_r   <= load_unsigned_in;
            end
            if (state_r == ST_WAIT_RD && dmem_rvalid_in) begin
                load_data_r <= ld_data_s;
            end
            if (state_s == ST_ERR) begin
                err_bus_r <= (state_r != ST_IDLE);
            end
        end
    end

    assign dmem_req_out   = (state_r == ST_REQ);
    assign dmem_we_out    = we_r;
    assign dmem_addr_out  = addr_r;
    assign dmem_wdata_out = wdata_r;
    assign dmem_be_out    = be_r;
    assign stall_out      = stall_s;
    assign load_data_out  = load_data_r;
    assign load_valid_out = (state_r == ST_DONE) & ~we_r & ~flush_in;
    assign misaligned_out = (state_r == ST_ERR) & ~err_bus_r & ~flush_in;
    assign bus_err_out    = (state_r == ST_ERR) & err_bus_r & ~flush_in;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus randomized transactions
// scored against a transaction-level timeline model.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    localparam int T = 4;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        req_valid_in, is_load_in, mem_wr_req_in, load_unsigned_in, flush_in;
    logic [1:0]  load_size_in;
    logic [31:0] addr_in, wdata_in, dmem_rdata_in;
    logic        dmem_ready_in, dmem_rvalid_in;
    logic        dmem_req_out, dmem_we_out, stall_out, load_valid_out, misaligned_out, bus_err_out;
    logic [31:0] dmem_addr_out, dmem_wdata_out, load_data_out;
    logic [3:0]  dmem_be_out;

    lsu_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .req_valid_in(req_valid_in),
        .is_load_in(is_load_in), .mem_wr_req_in(mem_wr_req_in), .load_size_in(load_size_in),
        .load_unsigned_in(load_unsigned_in), .addr_in(addr_in), .wdata_in(wdata_in),
        .flush_in(flush_in), .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out),
        .dmem_addr_out(dmem_addr_out), .dmem_wdata_out(dmem_wdata_out), .dmem_be_out(dmem_be_out),
        .dmem_ready_in(dmem_ready_in), .dmem_rvalid_in(dmem_rvalid_in), .dmem_rdata_in(dmem_rdata_in),
        .stall_out(stall_out), .load_valid_out(load_valid_out), .load_data_out(load_data_out),
        .misaligned_out(misaligned_out), .bus_err_out(bus_err_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic        ld;
        logic [1:0]  size;
        logic [31:0] addr;
        logic        uns;
        logic [31:0] wd;
        logic [31:0] rd;
    } instr_t;

    int n_checks = 0;
    int n_errors = 0;

    logic        chk_en = 1'b0, chk_bus, chk_ld;
    logic        e_stall, e_req, e_we, e_lv, e_mis, e_berr;
    logic [31:0] e_addr, e_wd, e_ld;
    logic [3:0]  e_be;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: access geometry from the size and byte offset
    function automatic int nbytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic m_mis(input instr_t c);
        int n;
        n = nbytes(c.size);
        return (n == 0) || ((int'(c.addr[1:0]) % n) != 0);
    endfunction

    function automatic logic [3:0] m_be(input instr_t c);
        int n, off;
        logic [3:0] be;
        n = nbytes(c.size);
        off = int'(c.addr[1:0]);
        for (int b = 0; b < 4; b++) be[b] = (b >= off) && (b < off + n);
        return be;
    endfunction

    function automatic logic [31:0] m_wd(input instr_t c);
        int n;
        logic [31:0] w;
        n = nbytes(c.size);
        if (n == 0) n = 4;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = c.wd[8*(b % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_ld(input instr_t c);
        int n, off;
        logic [31:0] v;
        n = nbytes(c.size);
        off = int'(c.addr[1:0]);
        v = 32'h0000_0000;
        for (int k = 0; k < n; k++) v[8*k +: 8] = c.rd[8*(off+k) +: 8];
        if (!c.uns && n < 4 && v[8*n-1]) begin
            for (int k = 8*n; k < 32; k++) v[k] = 1'b1;
        end
        return v;
    endfunction

    // Single compare point: every cycle, half a period after the inputs change
    always @(negedge clk_in) begin
        if (chk_en) begin
            chk("stall", stall_out, e_stall);
            chk("dmem_req", dmem_req_out, e_req);
            chk("load_valid", load_valid_out, e_lv);
            chk("misaligned", misaligned_out, e_mis);
            chk("bus_err", bus_err_out, e_berr);
            if (chk_bus) begin
                chk("dmem_we", dmem_we_out, e_we);
                chk("dmem_addr", dmem_addr_out, e_addr);
                chk("dmem_be", dmem_be_out, e_be);
                chk("dmem_wdata", dmem_wdata_out, e_wd);
            end
            if (chk_ld) chk("load_data", load_data_out, e_ld);
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_exp();
        e_stall = 1'b0; e_req = 1'b0; e_lv = 1'b0; e_mis = 1'b0; e_berr = 1'b0;
        chk_bus = 1'b0; chk_ld = 1'b0;
    endtask

    task automatic drive_instr(input instr_t c, input logic rv);
        req_valid_in     = rv;
        is_load_in       = c.ld;
        mem_wr_req_in    = ~c.ld;
        load_size_in     = c.size;
        load_unsigned_in = c.uns;
        addr_in          = c.addr;
        wdata_in         = c.wd;
    endtask

    function automatic instr_t mk(input logic ld, input logic [1:0] sz, input logic [31:0] a,
                                  input logic u, input logic [31:0] wd, input logic [31:0] rd);
        instr_t c;
        c.ld = ld; c.size = sz; c.addr = a; c.uns = u; c.wd = wd; c.rd = rd;
        return c;
    endfunction

    function automatic instr_t gen_instr();
        instr_t c;
        int r;
        r = int'($urandom_range(0, 9));
        c.ld = 1'($urandom_range(0, 1));
        c.size = (r == 9) ? 2'b11 : 2'(r % 3);
        c.addr = $urandom;
        c.uns = 1'($urandom_range(0, 1));
        c.wd = $urandom;
        c.rd = $urandom;
        if ($urandom_range(0, 3) != 0) begin
            if (c.size == 2'b01) c.addr[0] = 1'b0;
            if (c.size == 2'b10) c.addr[1:0] = 2'b00;
        end
        return c;
    endfunction

    // Read-response cycles after a cancelled load: stall follows req_valid
    task automatic drain(input int n, input instr_t nx, input logic nx_rv);
        for (int i = 1; i <= n; i++) begin
            clear_exp();
            drive_instr(nx, nx_rv);
            e_stall = nx_rv;
            flush_in = 1'b0;
            dmem_rvalid_in = (i == n);
            dmem_rdata_in = $urandom;
            step();
        end
        dmem_rvalid_in = 1'b0;
    endtask

    // fk: 0 none, 1 flush in first REQ cycle (ready low), 2 flush on handshake,
    //     3 flush in first WAIT_RD cycle, 4 flush in DONE/ERR
    task automatic run_txn(input instr_t c, input instr_t nx, input int dr, input int dv,
                           input int fk, input logic nx_rv);
        clear_exp();
        drive_instr(c, 1'b1);
        flush_in = 1'b0; dmem_ready_in = 1'b0; dmem_rvalid_in = 1'b0;
        e_stall = 1'b1;
        step();
        if (m_mis(c)) begin
            clear_exp();
            e_mis = (fk != 4);
            flush_in = (fk == 4);
            step();
            flush_in = 1'b0;
            return;
        end
        for (int k = 0; ; k++) begin
            clear_exp();
            e_stall = 1'b1; e_req = 1'b1; chk_bus = 1'b1;
            e_we = ~c.ld; e_addr = {c.addr[31:2], 2'b00}; e_be = m_be(c); e_wd = m_wd(c);
            dmem_ready_in = (k == dr);
            dmem_rdata_in = $urandom;
            flush_in = (fk == 1 && k == 0) || (fk == 2 && k == dr);
            step();
            if (fk == 1 && k == 0) begin
                flush_in = 1'b0; dmem_ready_in = 1'b0;
                return;
            end
            if (k == dr) break;
            if (k == T - 1) begin
                clear_exp();
                dmem_ready_in = 1'b0;
                e_berr = (fk != 4);
                flush_in = (fk == 4);
                step();
                flush_in = 1'b0;
                return;
            end
        end
        dmem_ready_in = 1'b0;
        flush_in = 1'b0;
        if (!c.ld) begin
            if (fk == 2) return;
            clear_exp();
            flush_in = (fk == 4);
            step();
            flush_in = 1'b0;
            return;
        end
        if (fk == 2) begin
            drain(dv, nx, nx_rv);
            return;
        end
        for (int j = 1; j <= dv; j++) begin
            clear_exp();
            e_stall = 1'b1;
            dmem_rvalid_in = (j == dv);
            dmem_rdata_in = (j == dv) ? c.rd : $urandom;
            flush_in = (fk == 3 && j == 1);
            step();
            if (fk == 3 && j == 1) begin
                dmem_rvalid_in = 1'b0; flush_in = 1'b0;
                drain(dv - 1, nx, nx_rv);
                return;
            end
        end
        dmem_rvalid_in = 1'b0;
        clear_exp();
        e_lv = (fk != 4); chk_ld = (fk != 4); e_ld = m_ld(c);
        flush_in = (fk == 4);
        step();
        flush_in = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            int mode;
            clear_exp();
            mode = int'($urandom_range(0, 2));
            req_valid_in = (mode != 0);
            is_load_in = (mode == 1);
            mem_wr_req_in = 1'b0;
            flush_in = (mode == 1);
            step();
        end
        flush_in = 1'b0;
        req_valid_in = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, dmem_req_out, 1'b0);
        chk({tag, "_we"}, dmem_we_out, 1'b0);
        chk({tag, "_addr"}, dmem_addr_out, 32'h0000_0000);
        chk({tag, "_wdata"}, dmem_wdata_out, 32'h0000_0000);
        chk({tag, "_be"}, dmem_be_out, 4'b0000);
        chk({tag, "_stall"}, stall_out, 1'b0);
        chk({tag, "_lv"}, load_valid_out, 1'b0);
        chk({tag, "_ldata"}, load_data_out, 32'h0000_0000);
        chk({tag, "_mis"}, misaligned_out, 1'b0);
        chk({tag, "_berr"}, bus_err_out, 1'b0);
    endtask

    instr_t cur, nxt;

    initial begin
        int dr, dv, fk, r;
        rst_n_in = 1'b0;
        req_valid_in = 1'b0; is_load_in = 1'b0; mem_wr_req_in = 1'b0; load_size_in = 2'b00;
        load_unsigned_in = 1'b0; addr_in = 32'h0; wdata_in = 32'h0; flush_in = 1'b0;
        dmem_ready_in = 1'b0; dmem_rvalid_in = 1'b0; dmem_rdata_in = 32'h0;
        clear_exp();
        repeat (2) step();
        chk_all_zero("reset");
        rst_n_in = 1'b1;
        chk_en = 1'b1;
        step();

        // Store byte 0xA5 to 0x1003, ready on first REQ cycle
        cur = mk(1'b0, 2'b00, 32'h0000_1003, 1'b0, 32'h1234_56A5, 32'h0);
        run_txn(cur, cur, 0, 1, 0, 1'b0);
        chk("st_byte_be", dmem_be_out, 4'b1000);
        chk("st_byte_wdata", dmem_wdata_out, 32'hA5A5_A5A5);
        chk("st_byte_addr", dmem_addr_out, 32'h0000_1000);

        // Signed and unsigned half loads from 0x2002, rvalid 2 cycles after ready
        cur = mk(1'b1, 2'b01, 32'h0000_2002, 1'b0, 32'h0, 32'h8001_1234);
        run_txn(cur, cur, 0, 2, 0, 1'b0);
        chk("ld_half_s", load_data_out, 32'hFFFF_8001);
        cur.uns = 1'b1;
        run_txn(cur, cur, 1, 2, 0, 1'b0);
        chk("ld_half_u", load_data_out, 32'h0000_8001);

        // Misaligned word load
        cur = mk(1'b1, 2'b10, 32'h0000_3001, 1'b0, 32'h0, 32'h0);
        run_txn(cur, cur, 0, 1, 0, 1'b0);

        // Bus timeout with ready held low
        cur = mk(1'b0, 2'b10, 32'h0000_4000, 1'b0, 32'hDEAD_BEEF, 32'h0);
        run_txn(cur, cur, T + 3, 1, 0, 1'b0);

        // Flush in WAIT_RD, rvalid three cycles later, new load waiting in DRAIN
        cur = mk(1'b1, 2'b10, 32'h0000_5000, 1'b0, 32'h0, 32'hCAFE_F00D);
        nxt = mk(1'b1, 2'b00, 32'h0000_6001, 1'b0, 32'h0, 32'h1122_8344);
        run_txn(cur, nxt, 0, 4, 3, 1'b1);
        run_txn(nxt, nxt, 0, 1, 0, 1'b0);
        chk("ld_after_drain", load_data_out, 32'hFFFF_FF83);

        // Asynchronous reset while a request is on the bus
        cur = mk(1'b1, 2'b10, 32'h0000_7000, 1'b0, 32'h0, 32'h0);
        clear_exp();
        drive_instr(cur, 1'b1);
        e_stall = 1'b1;
        step();
        chk_en = 1'b0;
        @(negedge clk_in);
        chk("req_before_rst", dmem_req_out, 1'b1);
        #1;
        rst_n_in = 1'b0;
        req_valid_in = 1'b0;
        #1;
        chk_all_zero("async_rst");
        dmem_rvalid_in = 1'b1;
        step();
        rst_n_in = 1'b1;
        step();
        dmem_rvalid_in = 1'b0;
        chk_all_zero("late_rvalid");
        clear_exp();
        chk_en = 1'b1;
        cur = mk(1'b1, 2'b00, 32'h0000_8002, 1'b1, 32'h0, 32'h00F0_0000);
        run_txn(cur, cur, 0, 1, 0, 1'b0);
        chk("ld_after_rst", load_data_out, 32'h0000_00F0);

        // Randomized transactions
        cur = gen_instr();
        for (int i = 0; i < 300; i++) begin
            nxt = gen_instr();
            r = int'($urandom_range(0, 9));
            dr = (r < 6) ? (r % 3) : ((r < 8) ? 3 : T + 1);
            dv = int'($urandom_range(1, 3));
            fk = int'($urandom_range(0, 7));
            if (fk < 4) fk = 0;
            else fk = fk - 3;
            if (fk == 1 && dr < 1) fk = 0;
            if (fk == 2 && dr >= T) fk = 0;
            if (fk == 3 && (!cur.ld || dv < 2 || dr >= T)) fk = 0;
            run_txn(cur, nxt, dr, dv, fk, 1'($urandom_range(0, 1)));
            idle_gap(int'($urandom_range(0, 2)));
            cur = nxt;
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
